// File: rtl/mouse_packet_decoder.sv
// Assembles 3-byte PS/2 stream-mode packets and tracks a clamped absolute pointer
// position plus button/status byte. Drives the byte receiver's READ_ENABLE.
module mouse_packet_decoder #(
  parameter int unsigned MAX_X          = 160,
  parameter int unsigned MAX_Y          = 120,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       STREAM_EN,
  input  logic [7:0] BYTE_READ,
  input  logic [1:0] BYTE_ERROR_CODE,
  input  logic       BYTE_READY,
  output logic       READ_ENABLE,
  output logic [7:0] MOUSE_X,
  output logic [7:0] MOUSE_Y,
  output logic [7:0] MOUSE_STATUS,
  output logic       PACKET_VALID,
  output logic       FRAME_ERROR
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic signed [10:0] X_HI = 11'(MAX_X - 1);
  localparam logic signed [10:0] Y_HI = 11'(MAX_Y - 1);
  localparam logic [7:0] X_RST = 8'(MAX_X / 2);
  localparam logic [7:0] Y_RST = 8'(MAX_Y / 2);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_B1,
    WAIT_B2,
    WAIT_B3,
    COMMIT
  } state_t;

  state_t        state;
  logic [7:0]    status_q;
  logic [7:0]    dx_q;
  logic [7:0]    dy_q;
  logic [TW-1:0] tcount;

  logic byte_bad;
  logic timeout;

  assign byte_bad = (BYTE_ERROR_CODE != 2'b00);
  assign timeout  = (tcount == T_LAST);

  // 9-bit signed delta (saturated on overflow), added in 11 bits and clamped to 0..hi.
  function automatic logic [7:0] next_pos(input logic [7:0] pos, input logic sign,
                                          input logic ovf, input logic [7:0] mag,
                                          input logic signed [10:0] hi);
    logic signed [10:0] delta;
    logic signed [10:0] sum;
    if (ovf) delta = sign ? -11'sd256 : 11'sd255;
    else     delta = {{3{sign}}, mag};
    sum = $signed({3'b000, pos}) + delta;
    if (sum < 11'sd0)    next_pos = 8'd0;
    else if (sum > hi)   next_pos = hi[7:0];
    else                 next_pos = sum[7:0];
  endfunction

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      READ_ENABLE  <= 1'b0;
      MOUSE_X      <= X_RST;
      MOUSE_Y      <= Y_RST;
      MOUSE_STATUS <= 8'd0;
      PACKET_VALID <= 1'b0;
      FRAME_ERROR  <= 1'b0;
      status_q     <= 8'd0;
      dx_q         <= 8'd0;
      dy_q         <= 8'd0;
      tcount       <= '0;
    end else begin
      PACKET_VALID <= 1'b0;
      FRAME_ERROR  <= 1'b0;
      if (!STREAM_EN) begin
        // Disabling the stream silently abandons any partial packet.
        state       <= IDLE;
        READ_ENABLE <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state       <= WAIT_B1;
            READ_ENABLE <= 1'b1;
          end
          WAIT_B1: begin
            if (BYTE_READY) begin
              if (byte_bad || !BYTE_READ[3]) begin
                FRAME_ERROR <= 1'b1;
              end else begin
                status_q <= BYTE_READ;
                tcount   <= '0;
                state    <= WAIT_B2;
              end
            end
          end
          WAIT_B2: begin
            if (timeout) begin
              FRAME_ERROR <= 1'b1;
              state       <= WAIT_B1;
            end else if (BYTE_READY) begin
              if (byte_bad) begin
                FRAME_ERROR <= 1'b1;
                state       <= WAIT_B1;
              end else begin
                dx_q   <= BYTE_READ;
                tcount <= '0;
                state  <= WAIT_B3;
              end
            end else begin
              tcount <= tcount + 1'b1;
            end
          end
          WAIT_B3: begin
            if (timeout) begin
              FRAME_ERROR <= 1'b1;
              state       <= WAIT_B1;
            end else if (BYTE_READY) begin
              if (byte_bad) begin
                FRAME_ERROR <= 1'b1;
                state       <= WAIT_B1;
              end else begin
                dy_q        <= BYTE_READ;
                tcount      <= '0;
                state       <= COMMIT;
                READ_ENABLE <= 1'b0;
              end
            end else begin
              tcount <= tcount + 1'b1;
            end
          end
          COMMIT: begin
            MOUSE_X      <= next_pos(MOUSE_X, status_q[4], status_q[6], dx_q, X_HI);
            MOUSE_Y      <= next_pos(MOUSE_Y, status_q[5], status_q[7], dy_q, Y_HI);
            MOUSE_STATUS <= status_q;
            PACKET_VALID <= 1'b1;
            state        <= WAIT_B1;
            READ_ENABLE  <= 1'b1;
          end
          default: begin
            state       <= IDLE;
            READ_ENABLE <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
